// File: rtl/ad4003_sample_packer_if.sv
// ad4003_sample_packer_if: AXI4-Stream link carrying packed AD4003 sample words to the DMA.
interface ad4003_sample_packer_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/ad4003_sample_packer.sv
// ad4003_sample_packer: tags AD4003 A/B sample pairs with a counter, buffers them and streams 32-bit words.
module ad4003_sample_packer #(
  parameter int ADC_DATA_WIDTH = 18,
  parameter int FIFO_DEPTH = 16,
  parameter int PACKET_LEN = 64
) (
  input  logic                          clk_100,
  input  logic                          rst_n,
  input  logic                          acq_en,
  input  logic                          sample_strobe,
  input  logic [ADC_DATA_WIDTH-1:0]     parallel_data_a,
  input  logic [ADC_DATA_WIDTH-1:0]     parallel_data_b,
  ad4003_sample_packer_if.master        m_axis,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(PACKET_LEN);
  localparam int EW = 13 + 2 * ADC_DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} state_t;
  state_t state, state_nxt;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [12:0] sample_cnt, out_cnt;
  logic [ADC_DATA_WIDTH-1:0] out_a, out_b;
  logic acq_q, acq_qq, clr, take, full, empty, push, pop;
  assign clr   = acq_q & ~acq_qq;
  assign take  = sample_strobe & acq_en;
  assign full  = fifo_level == (AW+1)'(FIFO_DEPTH);
  assign empty = fifo_level == '0;
  assign push  = take & ~full;
  // Dropped strobes still advance the count so the gap shows up downstream
  always_ff @(posedge clk_100 or negedge rst_n)
    if (!rst_n) begin
      acq_q      <= 1'b0;
      acq_qq     <= 1'b0;
      sample_cnt <= '0;
      overflow   <= 1'b0;
    end else begin
      acq_q      <= acq_en;
      acq_qq     <= acq_q;
      sample_cnt <= clr ? '0 : sample_cnt + 13'(take);
      overflow   <= ~clr & (overflow | (take & full));
    end
  always_ff @(posedge clk_100)
    if (push) mem[wr_ptr] <= {clr ? 13'd0 : sample_cnt, parallel_data_a, parallel_data_b};
  always_ff @(posedge clk_100 or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_ptr + AW'(pop);
      fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk_100 or negedge rst_n)
    if (!rst_n) begin
      state                   <= IDLE;
      {out_cnt, out_a, out_b} <= '0;
    end else begin
      state <= state_nxt;
      if (pop) {out_cnt, out_a, out_b} <= mem[rd_ptr];
    end
  // Popping at the SEND_B handshake keeps pairs back-to-back without a bubble
  always_comb begin
    pop = ~empty & ((state == IDLE) | ((state == SEND_B) & m_axis.tready));
    state_nxt = state;
    if (pop) state_nxt = SEND_A;
    else if (state == SEND_A && m_axis.tready) state_nxt = SEND_B;
    else if (state == SEND_B && m_axis.tready) state_nxt = IDLE;
    m_axis.tvalid = state != IDLE;
    m_axis.tlast  = (state == SEND_B) && (&out_cnt[LW-1:0]);
    m_axis.tdata  = state == SEND_A ? {1'b0, out_cnt, out_a} :
                    state == SEND_B ? {1'b1, out_cnt, out_b} : '0;
  end
endmodule

// File: tb/tb_ad4003_sample_packer.sv
// tb_ad4003_sample_packer: directed and randomized checks of the sample packer with an expected-word queue.
module tb_ad4003_sample_packer;
  logic clk_100 = 0, rst_n = 1, acq_en = 0, sample_strobe = 0;
  logic [17:0] pa = '0, pb = '0;
  logic [4:0] fifo_level;
  logic overflow;
  logic [12:0] m_cnt = '0;
  logic [32:0] exp_q[$];
  logic [33:0] prev_word = '0;
  logic stall_prev = 0, done = 0;
  int n_chk = 0, n_err = 0;
  ad4003_sample_packer_if axis();
  ad4003_sample_packer #(.FIFO_DEPTH(16), .PACKET_LEN(4)) dut (
    .clk_100(clk_100), .rst_n(rst_n), .acq_en(acq_en), .sample_strobe(sample_strobe),
    .parallel_data_a(pa), .parallel_data_b(pb), .m_axis(axis),
    .fifo_level(fifo_level), .overflow(overflow)
  );
  always #5 clk_100 = ~clk_100;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  // Every handshake must match the queue head; a stalled word must not move
  always @(negedge clk_100) begin
    if (!rst_n) stall_prev = 0;
    else begin
      if (stall_prev) chk("hold", {axis.tvalid, axis.tlast, axis.tdata}, prev_word);
      if (axis.tvalid && axis.tready)
        chk("word", {axis.tlast, axis.tdata}, exp_q.size() != 0 ? exp_q.pop_front() : 33'bx);
      stall_prev = axis.tvalid && !axis.tready;
      prev_word = {axis.tvalid, axis.tlast, axis.tdata};
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_100);
    #1;
  endtask
  task automatic strb(input logic [17:0] a, input logic [17:0] b, input bit keep);
    sample_strobe = 1; pa = a; pb = b;
    if (acq_en) begin
      if (keep) begin
        exp_q.push_back({2'b00, m_cnt, a});
        exp_q.push_back({&m_cnt[1:0], 1'b1, m_cnt, b});
      end
      m_cnt++;
    end
    cyc(1);
    sample_strobe = 0;
  endtask
  task automatic rise();
    acq_en = 0; cyc(2); acq_en = 1; cyc(3); m_cnt = '0;
  endtask
  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || axis.tvalid) && t < 3000) begin cyc(1); t++; end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_idle", axis.tvalid, 0);
  endtask
  initial begin
    axis.tready = 0;
    #2 rst_n = 0;
    cyc(2);
    chk("rst_tvalid", axis.tvalid, 0);
    chk("rst_tlast", axis.tlast, 0);
    chk("rst_tdata", axis.tdata, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1;
    cyc(1);
    for (int i = 0; i < 3; i++) strb(18'h155, 18'h2AA, 1);
    cyc(5);
    chk("dis_tvalid", axis.tvalid, 0);
    chk("dis_level", fifo_level, 0);
    rise();
    axis.tready = 1;
    strb(18'h1FFFF, 18'h20000, 1);
    @(negedge clk_100);
    chk("lat_n1", axis.tvalid, 0);
    @(negedge clk_100);
    chk("a_valid", axis.tvalid, 1);
    chk("a_data", axis.tdata, 32'h0001FFFF);
    chk("a_last", axis.tlast, 0);
    @(negedge clk_100);
    chk("b_data", axis.tdata, 32'h80020000);
    chk("b_last", axis.tlast, 0);
    cyc(1);
    drain();
    rise();
    for (int i = 0; i < 8; i++) strb(18'(i * 3 + 1), 18'(i * 7 + 2), 1);
    drain();
    axis.tready = 0;
    for (int i = 0; i < 20; i++) strb(18'(i + 'h100), 18'(i + 'h200), i < 17);
    cyc(20);
    chk("bp_level", fifo_level, 16);
    chk("bp_ovf", overflow, 1);
    chk("bp_head", axis.tdata, {1'b0, 13'd8, 18'h100});
    axis.tready = 1;
    drain();
    chk("ovf_sticky", overflow, 1);
    strb(18'h5, 18'h6, 1);
    drain();
    rise();
    chk("ovf_clr", overflow, 0);
    strb(18'h3, 18'h4, 1);
    drain();
    rise();
    done = 0;
    fork
      begin
        for (int i = 0; i < 500; i++) begin
          strb(18'($urandom), 18'($urandom), 1);
          cyc($urandom_range(2, 8));
        end
        done = 1;
      end
      begin
        while (!done) begin
          axis.tready = $urandom_range(3) != 0;
          cyc(1);
        end
      end
    join
    axis.tready = 1;
    drain();
    chk("rnd_ovf", overflow, 0);
    rise();
    for (int i = 0; i < 8193; i++) begin
      strb(18'(i), 18'(i ^ 'h2AAAA), 1);
      cyc(1);
    end
    drain();
    axis.tready = 0;
    for (int i = 0; i < 6; i++) strb(18'(i + 'h10), 18'(i + 'h20), 1);
    cyc(2);
    axis.tready = 1;
    cyc(1);
    axis.tready = 0;
    @(negedge clk_100);
    chk("mid_send_b", axis.tdata[31], 1);
    chk("mid_level", fifo_level, 5);
    rst_n = 0;
    @(negedge clk_100);
    chk("mrst_tvalid", axis.tvalid, 0);
    chk("mrst_level", fifo_level, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_tdata", axis.tdata, 0);
    exp_q.delete();
    m_cnt = '0;
    @(posedge clk_100);
    #1 rst_n = 1;
    cyc(3);
    axis.tready = 1;
    strb(18'h1234, 18'h2345, 1);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
